bundle_cnt: RTL and testbench

Multi-channel bundling accumulator: CH per-channel counters, each advanced by one input bit per accepted beat, plus a shared sample counter. On a finish request, every channel is thresholded against half the sample count to produce a binarised (majority) vector. This is the generalised successor of the single-bit incrementer. It sits between the hypervector encoder and the class-memory write path, with valid/ready handshakes on both sides.

---
 rtl/bundle_pkg.sv | 32 +++
 rtl/cnt_lane.sv | 30 +++
 rtl/bundle_cnt.sv | 120 ++++++++++++
 tb/tb_bundle_cnt.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bundle_pkg.sv
// Shared types and helpers for the bundling accumulator.
// States, default sizes and the per-channel majority compare.
package bundle_pkg;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        THRESH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CH_DEF = 64;
    localparam int DW_DEF = 8;

    // Wide enough for {acc,1'b0} at any practical counter width.
    localparam int MW = 33;

    function automatic logic maj_bit(
        input logic [MW-1:0] acc2,
        input logic [MW-1:0] n,
        input logic          tie
    );
        logic r;
        r = 1'b0;
        if (acc2 > n) begin
            r = 1'b1;
        end else if (acc2 == n) begin
            r = tie;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_lane.sv
// One channel counter of the bundling accumulator.
// Synchronous clear wins over increment.
module cnt_lane
    import bundle_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_inc,
    output logic [DW-1:0] o_cnt
);

    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bundle_cnt.sv
// Multi-channel bundling accumulator with majority readout.
// Optional BUNDLE_TIE_EN adds tie_bits; otherwise ties resolve to 0.
module bundle_cnt
    import bundle_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CH-1:0] in_bits,
    input  logic          finish,
`ifdef BUNDLE_TIE_EN
    input  logic [CH-1:0] tie_bits,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CH-1:0] out_bits,
    output logic [DW-1:0] sample_cnt
);

    localparam logic [DW-1:0] CNT_MAX = '1;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_sample;
    logic [CH-1:0] r_out_bits;
    logic [DW-1:0] w_acc [CH];
    logic [CH-1:0] w_tie;
    logic [CH-1:0] w_maj;
    logic          w_accept;
    logic          w_flush;
    logic          w_clear;

`ifdef BUNDLE_TIE_EN
    assign w_tie = tie_bits;
`else
    assign w_tie = '0;
`endif

    // Full at max count, so lanes can never wrap.
    assign in_ready  = (r_state == ACC) && (r_sample != CNT_MAX);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready && !clr;
    assign w_flush   = (r_state == DONE) && out_ready;
    assign w_clear   = clr || w_flush;

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_lane
            cnt_lane #(
                .DW(DW)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_clear),
                .i_en  (w_accept),
                .i_inc (in_bits[g]),
                .o_cnt (w_acc[g])
            );
        end
    endgenerate

    always_comb begin
        w_maj = '0;
        for (int i = 0; i < CH; i++) begin
            w_maj[i] = maj_bit(MW'({w_acc[i], 1'b0}),
                               MW'(r_sample),
                               w_tie[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = ACC;
        end else begin
            unique case (r_state)
                ACC:     if (finish) w_next = THRESH;
                THRESH:  w_next = DONE;
                DONE:    if (out_ready) w_next = ACC;
                default: w_next = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
        end else if (w_clear) begin
            r_sample <= '0;
        end else if (w_accept) begin
            r_sample <= r_sample + 1'b1;
        end
    end

    // Result is captured once; clr leaves the stale value in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bits <= '0;
        end else if (r_state == THRESH && !clr) begin
            r_out_bits <= w_maj;
        end
    end

    assign out_bits   = r_out_bits;
    assign sample_cnt = r_sample;

endmodule

// File: tb/tb_bundle_cnt.sv
// Self-checking bench for bundle_cnt at CH=4, DW=3.
// Expected results come from per-channel counts kept in plain integers.
module tb_bundle_cnt;

    localparam int CH = 4;
    localparam int DW = 3;
    localparam int NMAX = (1 << DW) - 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [CH-1:0] in_bits;
    logic          finish;
    logic [CH-1:0] tie_bits;
    logic          out_valid;
    logic          out_ready;
    logic [CH-1:0] out_bits;
    logic [DW-1:0] sample_cnt;

    int n_tests;
    int n_fail;
    int m_cnt [CH];
    int m_n;

    bundle_cnt #(
        .CH(CH),
        .DW(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .finish     (finish),
`ifdef BUNDLE_TIE_EN
        .tie_bits   (tie_bits),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH-1:0] eff_tie(input logic [CH-1:0] t);
`ifdef BUNDLE_TIE_EN
        return t;
`else
        return '0;
`endif
    endfunction

    // Majority of each channel against the sample count.
    function automatic logic [CH-1:0] model_vec(input logic [CH-1:0] t);
        logic [CH-1:0] v;
        logic [CH-1:0] et;
        et = eff_tie(t);
        v = '0;
        for (int i = 0; i < CH; i++) begin
            if (2 * m_cnt[i] > m_n) v[i] = 1'b1;
            else if (2 * m_cnt[i] == m_n) v[i] = et[i];
            else v[i] = 1'b0;
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_n = 0;
    endtask

    task automatic model_beat(input logic [CH-1:0] b);
        if (m_n < NMAX) begin
            for (int i = 0; i < CH; i++) m_cnt[i] += int'(b[i]);
            m_n++;
        end
    endtask

    task automatic send_beat(input logic [CH-1:0] b);
        in_valid = 1'b1;
        in_bits  = b;
        if (in_ready) model_beat(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr = 1'b0; in_valid = 1'b0; in_bits = '0;
        finish = 1'b0; tie_bits = '0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    // finish, THRESH, then checks of the DONE result.
    task automatic finish_and_check(input string nm, input logic [CH-1:0] t);
        logic [CH-1:0] ev;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tie_bits = t;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_thresh: out_valid=%b in_ready=%b required 0 0", nm, out_valid, in_ready);
        end
        tick();
        ev = model_vec(t);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: out_valid=%b required 1", nm, out_valid);
        end
        n_tests++;
        if (out_bits !== ev) begin
            n_fail++;
            $display("FAIL %s_bits: out_bits=%b required %b", nm, out_bits, ev);
        end
        n_tests++;
        if (sample_cnt !== DW'(m_n)) begin
            n_fail++;
            $display("FAIL %s_cnt: sample_cnt=%0d required %0d", nm, sample_cnt, m_n);
        end
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_clear();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s_hs: out_valid=%b in_ready=%b cnt=%0d required 0 1 0", nm, out_valid, in_ready, sample_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_cnt !== '0 || out_bits !== '0) begin
            n_fail++;
            $display("FAIL reset: ov=%b ir=%b cnt=%0d bits=%b required 0 1 0 0000", out_valid, in_ready, sample_cnt, out_bits);
        end
    endtask

    task automatic test_basic();
        send_beat(4'b0011);
        send_beat(4'b0101);
        send_beat(4'b0001);
        n_tests++;
        if (sample_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_acc: sample_cnt=%0d required 3", sample_cnt);
        end
        finish_and_check("basic", 4'b0000);
        handshake("basic");
    endtask

    task automatic test_tie();
        send_beat(4'b0011);
        send_beat(4'b0101);
        finish_and_check("tie", 4'b1110);
        handshake("tie");
    endtask

    task automatic test_full();
        in_valid = 1'b1;
        in_bits  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (in_ready) model_beat(in_bits);
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || sample_cnt !== 3'd7) begin
            n_fail++;
            $display("FAIL full: in_ready=%b cnt=%0d required 0 7", in_ready, sample_cnt);
        end
        finish_and_check("full", 4'b0000);
        handshake("full");
    endtask

    task automatic test_backpressure();
        logic [CH-1:0] held;
        send_beat(4'b1100);
        send_beat(4'b1010);
        send_beat(4'b1000);
        finish_and_check("bp", 4'b0110);
        held = out_bits;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_bits !== held || in_ready !== 1'b0 || sample_cnt !== DW'(m_n)) begin
                n_fail++;
                $display("FAIL bp_hold: ov=%b bits=%b ir=%b cnt=%0d required 1 %b 0 %0d", out_valid, out_bits, in_ready, sample_cnt, held, m_n);
            end
        end
        handshake("bp");
    endtask

    task automatic test_clr();
        bit seen;
        send_beat(4'b1111);
        send_beat(4'b1111);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_tests++;
        if (seen || sample_cnt !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_thresh: seen_valid=%b cnt=%0d ir=%b required 0 0 1", seen, sample_cnt, in_ready);
        end
        in_valid = 1'b1;
        in_bits  = 4'b1111;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (sample_cnt !== '0) begin
            n_fail++;
            $display("FAIL clr_beat: sample_cnt=%0d required 0", sample_cnt);
        end
        send_beat(4'b0000);
        finish_and_check("clr_post", 4'b0000);
        handshake("clr_post");
    endtask

    task automatic test_reset_mid();
        send_beat(4'b1111);
        send_beat(4'b0111);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 && in_ready !== 1'b1 || sample_cnt !== '0 || out_bits !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: ov=%b cnt=%0d bits=%b required 0 0 0000", out_valid, sample_cnt, out_bits);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_empty();
        finish_and_check("empty", 4'b1010);
        handshake("empty");
    endtask

    task automatic test_random();
        int nb;
        bit fin;
        logic [CH-1:0] t;
        logic [CH-1:0] held;
        for (int f = 0; f < 30; f++) begin
            nb = $urandom_range(0, 11);
            fin = 1'b0;
            for (int k = 0; k < nb; k++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bits  = CH'($urandom);
                n_tests++;
                if (in_ready !== (m_n != NMAX)) begin
                    n_fail++;
                    $display("FAIL rnd_ready: in_ready=%b required %b", in_ready, m_n != NMAX);
                end
                if (in_valid && m_n != NMAX) model_beat(in_bits);
                if (k == nb - 1 && $urandom_range(0, 1) == 1) begin
                    fin = 1'b1;
                    finish = 1'b1;
                end
                tick();
                in_valid = 1'b0;
                finish = 1'b0;
            end
            t = CH'($urandom);
            if (fin) begin
                tie_bits = t;
                tick();
                n_tests++;
                if (out_valid !== 1'b1 || out_bits !== model_vec(t) || sample_cnt !== DW'(m_n)) begin
                    n_fail++;
                    $display("FAIL rnd_fin_beat: ov=%b bits=%b cnt=%0d required 1 %b %0d", out_valid, out_bits, sample_cnt, model_vec(t), m_n);
                end
            end else begin
                finish_and_check("rnd", t);
            end
            held = out_bits;
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                tick();
                n_tests++;
                if (out_valid !== 1'b1 || out_bits !== held) begin
                    n_fail++;
                    $display("FAIL rnd_hold: ov=%b bits=%b required 1 %b", out_valid, out_bits, held);
                end
            end
            handshake("rnd");
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_clear();
        test_reset();
        test_basic();
        test_tie();
        test_full();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_empty();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
